serial_transmitter: RTL

8N1 UART transmitter peripheral for the KCPSM3 port bus, the outbound counterpart of the existing serial receiver. The CPU pushes bytes through a port write into a 16-deep FIFO. A baud-rate state machine shifts each byte out on `txd`. A `done` level tells the CPU when everything has left the wire, and can be used as an interrupt source or polled. The block sits beside the receiver on the `1000001x` port range, or any other decoded range, and shares the CPU `in_port` via OR-combined `data_out`.

---
 rtl/serial_transmitter_if.sv | 12 +
 rtl/serial_transmitter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/serial_transmitter_if.sv
// Port-bus side of the serial transmitter: one register access per cycle,
// read data returned combinationally for OR-combining onto the CPU in_port.
interface serial_transmitter_if;
  logic       en;
  logic       wr;
  logic       addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output en, wr, addr, data_in, input data_out);
  modport slave  (input en, wr, addr, data_in, output data_out);
endinterface

// File: rtl/serial_transmitter.sv
// 8N1 UART transmitter: CPU-fed FIFO drained by a baud-rate shifter,
// with status/count readback and a registered all-sent flag.
module serial_transmitter #(
  parameter int CLOCK_DIVISOR   = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_transmitter_if.slave  bus,
  output logic                 txd,
  output logic                 done
);
  localparam int N     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << N;
  localparam logic [N:0]  FULL_CNT    = (N+1)'(DEPTH);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLOCK_DIVISOR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [N-1:0]   rdPtr, wrPtr;
  logic [N:0]     count;
  logic [7:0]     shiftReg;
  logic [2:0]     bitIdx;
  logic [15:0]    baudCnt;
  logic           overflow;
  logic           bitEnd, pop, push, accept, ovfClear;

  assign bitEnd   = (baudCnt == 16'd0);
  // The shifter takes a new byte when idle or at the last cycle of a stop bit.
  assign pop      = (count != '0) && ((state == IDLE) || (state == STOP && bitEnd));
  assign push     = bus.en && bus.wr && !bus.addr;
  assign accept   = push && ((count < FULL_CNT) || pop);
  assign ovfClear = bus.en && bus.wr && bus.addr && bus.data_in[0];

  always_comb begin
    bus.data_out = 8'h00;
    if (bus.en && !bus.wr) begin
      if (bus.addr) bus.data_out[N:0] = count;
      else          bus.data_out[3:0] = {overflow, ~done, count == '0, count == FULL_CNT};
    end
  end

  always_ff @(posedge clk)
    if (accept) mem[wrPtr] <= bus.data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
      if (push && !accept) overflow <= 1'b1;
      else if (ovfClear)   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      done     <= 1'b1;
      shiftReg <= 8'h00;
      bitIdx   <= 3'd0;
      baudCnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shiftReg <= mem[rdPtr];
            baudCnt  <= BAUD_RELOAD;
            state    <= START;
            txd      <= 1'b0;
            done     <= 1'b0;
          end else begin
            txd  <= 1'b1;
            done <= 1'b1;
          end
        end
        START: begin
          if (bitEnd) begin
            baudCnt <= BAUD_RELOAD;
            bitIdx  <= 3'd0;
            txd     <= shiftReg[0];
            state   <= DATA;
          end else baudCnt <= baudCnt - 1'b1;
        end
        DATA: begin
          if (bitEnd) begin
            baudCnt <= BAUD_RELOAD;
            if (bitIdx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              // Next line value is the bit that becomes LSB after this shift.
              txd      <= shiftReg[1];
              shiftReg <= shiftReg >> 1;
              bitIdx   <= bitIdx + 1'b1;
            end
          end else baudCnt <= baudCnt - 1'b1;
        end
        STOP: begin
          if (bitEnd) begin
            if (pop) begin
              shiftReg <= mem[rdPtr];
              baudCnt  <= BAUD_RELOAD;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              txd   <= 1'b1;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else baudCnt <= baudCnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
